// File: rtl/sdram_req_queue.sv
// Request FIFO between a client and an SDRAM controller. Keeps request order,
// caps outstanding controller reads, and returns read data/errors one cycle later.
module sdram_req_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_LEN   = DATA_WIDTH / 8,
    parameter int DEPTH      = 4,
    parameter int MAX_RD     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_LEN-1:0]        c_wr,
    input  logic                       c_rd,
    input  logic [ADDR_WIDTH-1:0]      c_addr,
    input  logic [DATA_WIDTH-1:0]      c_wdata,
    output logic                       c_rdy,
    output logic                       c_rvalid,
    output logic [DATA_WIDTH-1:0]      c_rdata,
    output logic                       c_error,
    output logic [WORD_LEN-1:0]        m_wr,
    output logic                       m_rd,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [DATA_WIDTH-1:0]      m_wdata,
    input  logic                       m_rdy,
    input  logic                       m_rvalid,
    input  logic                       m_error,
    input  logic [DATA_WIDTH-1:0]      m_rdata,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WORD_LEN-1:0]   wr_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      rd_mem;

    logic [PW-1:0] wptr, rptr;
    logic [LW-1:0] count;
    logic [3:0]    outst;

    logic head_valid, head_rd, blocked;
    logic wr_req, push, bad_req, pop, rd_pop, rv_ok, orphan;

    // c_rdy is gated by rst_n so nothing is accepted while reset is held.
    assign c_rdy      = rst_n && (count < LW'(DEPTH));
    assign head_valid = (count != '0);
    assign head_rd    = rd_mem[rptr];
    assign blocked    = head_rd && (outst == 4'(MAX_RD));

    assign m_rd    = head_valid && head_rd && !blocked;
    assign m_wr    = head_valid ? wr_mem[rptr] : '0;
    assign m_addr  = addr_mem[rptr];
    assign m_wdata = data_mem[rptr];
    assign level   = count;

    assign wr_req  = |c_wr;
    assign push    = c_rdy && (c_rd ^ wr_req);
    assign bad_req = c_rdy && c_rd && wr_req;
    assign pop     = (m_rd || (|m_wr)) && m_rdy;
    assign rd_pop  = m_rd && m_rdy;
    assign rv_ok   = m_rvalid && (outst != '0);
    assign orphan  = m_rvalid && (outst == '0);

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            wr_mem[wptr]   <= c_wr;
            addr_mem[wptr] <= c_addr;
            data_mem[wptr] <= c_wdata;
            rd_mem[wptr]   <= c_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            outst    <= '0;
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            c_error  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            case ({rd_pop, rv_ok})
                2'b10:   outst <= outst + 4'd1;
                2'b01:   outst <= outst - 4'd1;
                default: outst <= outst;
            endcase
            c_rvalid <= rv_ok;
            if (rv_ok) c_rdata <= m_rdata;
            c_error  <= m_error || bad_req || orphan;
        end
    end
endmodule
